// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop line synchronizer, mid-bit sampling with a
// divisor latched at start-bit detection, one-cycle valid / frame_err pulses.
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] clks_per_bit,
  input  logic       UART_line,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state;
  logic       sync_q;
  logic       rx_s;
  logic [9:0] n_r;
  logic [9:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  logic [9:0] half_m1;
  logic [9:0] n_m1;

  assign half_m1 = {1'b0, n_r[9:1]} - 10'd1;
  assign n_m1    = n_r - 10'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= UART_line;
      rx_s   <= sync_q;
    end
  end

  // busy is registered alongside state so it tracks (state != IDLE) exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_r       <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            n_r   <= clks_per_bit;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == half_m1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DATA: begin
          if (cnt == n_m1) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        STOP: begin
          if (cnt == n_m1) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line idles so a break cannot start a new frame.
          if (rx_s) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the simplified UART link: the downstream stage that consumes the serial line driven by the transmitter. Detects a start bit on `UART_line`, samples 8N1 frames (8 data bits, LSB first, no parity, 1 stop bit) at mid-bit using a programmable clocks-per-bit divisor, and presents each received byte with a one-cycle valid pulse. Framing errors are flagged separately. Used at 57600 baud on a 25 MHz clock with `clks_per_bit` = 434.

## Interface
- No parameters; divisor is a port, matching the transmitter.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `clks_per_bit` input 10: clocks per bit, N. Legal range 4..1023.
- `UART_line` input 1: asynchronous serial input, idle high.
- `data` output 8: last correctly framed byte. Holds its value until the next good frame.
- `valid` output 1: one-cycle pulse when `data` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- `UART_line` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- N is latched into `n_r` on the IDLE→START transition. Changes to `clks_per_bit` while busy have no effect on the current frame.
- Define H = floor(n_r/2). Counter `cnt` clears on every state entry and on every sample.
- State machine:
  - **IDLE**: when `rx_s`=0, go to START.
  - **START**: at `cnt`=H-1, sample `rx_s`.
    - 0: go to DATA with `bit_idx`=0.
    - 1: glitch; go to IDLE with no output.
  - **DATA**: at `cnt`=n_r-1, sample `rx_s` into `shift[7]`, shifting right (LSB first). After `bit_idx`=7, go to STOP; otherwise increment `bit_idx`.
  - **STOP**: at `cnt`=n_r-1, sample `rx_s`.
    - 1: `data`<=`shift`, `valid` pulses, go to IDLE.
    - 0: `frame_err` pulses, `data` is unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering.
- `valid` and `frame_err` are registered and never high together.
- A new start bit is accepted in the first IDLE cycle, so back-to-back frames with exactly one stop bit are received.
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `cnt`=0, `bit_idx`=0, `shift`=0, `n_r`=0.
- Reset mid-frame aborts immediately and asynchronously. The partial frame is discarded with no pulse.

## Timing
- Synchronizer latency: a raw line change becomes visible on `rx_s` 2 edges later.
- Let E0 be the edge at which IDLE sees `rx_s`=0. `busy` is high from E0.
- Start bit is sampled at E0+H.
- Data bit i is sampled at E0+H+(i+1)·n_r, for i=0..7.
- Stop bit is sampled at E0+H+9·n_r. `data`, `valid` and `frame_err` update at this same edge.
- On a good stop bit, `busy` falls at that edge and the state is IDLE in the next cycle.
- Pulse width: `valid` and `frame_err` are each exactly one clock.
- Jitter tolerance: the sample point sits H cycles into each bit. Total drift over 10 bits must stay below H cycles.
- Width rules:
  - `cnt` is 10 bits and counts 0..n_r-1 without wrap.
  - `bit_idx` is 3 bits.
  - H is computed by a shift, with no rounding.

## Test plan
- **Good frame**: N=434, drive 0xA5 8N1 ideally.
  - `data`=0xA5, one `valid` pulse at E0+217+9·434.
  - `frame_err` stays 0 and `busy` drops afterwards.
- **Glitch rejection**: N=16, drive the line low for 5 cycles, then high.
  - No `valid` and no `frame_err`.
  - `busy` is high for 8 cycles, then IDLE.
- **Framing error / break**: N=16, `data` previously 0x5A, then hold the line low for 20 bit times.
  - One `frame_err` pulse; `data` stays 0x5A; `busy` stays high until the line returns high.
  - The next frame 0x11 is received correctly.
- **Back-to-back**: N=16, send 0x00 then 0xFF with one stop bit between them.
  - Two `valid` pulses, 160 cycles apart, with `data` 0x00 then 0xFF.
- **Reset mid-frame**: N=16, deassert-then-assert `rst` low during data bit 3.
  - Outputs go to reset values asynchronously with no pulses.
  - After release, frame 0x3C gives `data`=0x3C with `valid`.
- **Divisor latch**: change `clks_per_bit` from 16 to 20 mid-frame.
  - The current frame 0xC3 decodes at N=16.
  - The next frame 0x7E decodes at N=20.
